// File: rtl/ft245_fifo_responder.sv
// FT245-style device end: RX/TX byte FIFOs answering RD/WR strobes on USBX; `FT_LOOPBACK_EN adds LOOPBACK echo (WR -> RX FIFO).
// Latency: USBX valid 3 CLK after RD falls at the pin; a WR byte is pushed 3 CLK after WR falls at the pin.
// Backpressure: RXF/TXE/HOST_RXRDY pace the producers; overrun bytes are dropped, strobe overruns set sticky ERR bits.
module ft245_fifo_responder #(
  parameter int RX_AW     = 4,
  parameter int TX_AW     = 4,
  parameter int RXF_INACT = 10,
  parameter int TXE_INACT = 10
) (
  input  logic       CLK,
  input  logic       RSTN,
`ifdef FT_LOOPBACK_EN
  input  logic       LOOPBACK,
`endif
  input  logic       RD,
  input  logic       WR,
  inout  wire  [7:0] USBX,
  output logic       RXF,
  output logic       TXE,
  input  logic [7:0] HOST_RXD,
  input  logic       HOST_RXV,
  output logic       HOST_RXRDY,
  output logic [7:0] HOST_TXD,
  output logic       HOST_TXV,
  input  logic       HOST_TXACK,
  output logic [1:0] ERR
);

  localparam int RXD = 1 << RX_AW;
  localparam int TXD = 1 << TX_AW;
  localparam int RCW = $clog2(RXF_INACT + 1);
  localparam int WCW = $clog2(TXE_INACT + 1);

  typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_INACT} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ARMED, W_INACT} wstate_t;

  logic lb;
`ifdef FT_LOOPBACK_EN
  assign lb = LOOPBACK;
`else
  assign lb = 1'b0;
`endif

  // Sync chains reset to the active level; *_ok arms edge detection only after a real idle level is seen.
  logic       rd_s1, rd_s2, rd_d, rd_ok;
  logic       wr_s1, wr_s2, wr_d, wr_ok;
  logic [7:0] usbx_s1, usbx_s2, wr_byte;
  logic       live;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_s1   <= 1'b0;
      rd_s2   <= 1'b0;
      rd_d    <= 1'b0;
      rd_ok   <= 1'b0;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      wr_d    <= 1'b1;
      wr_ok   <= 1'b0;
      usbx_s1 <= 8'h00;
      usbx_s2 <= 8'h00;
      wr_byte <= 8'h00;
      live    <= 1'b0;
    end else begin
      rd_s1   <= RD;
      rd_s2   <= rd_s1;
      rd_d    <= rd_s2;
      rd_ok   <= rd_ok | rd_s2;
      wr_s1   <= WR;
      wr_s2   <= wr_s1;
      wr_d    <= wr_s2;
      wr_ok   <= wr_ok | ~wr_s2;
      usbx_s1 <= USBX;
      usbx_s2 <= usbx_s1;
      if (wr_s2) wr_byte <= usbx_s2;
      live    <= 1'b1;
    end
  end

  logic rd_fall, rd_rise, wr_rise, wr_fall;
  assign rd_fall = rd_ok & rd_d & ~rd_s2;
  assign rd_rise = rd_ok & ~rd_d & rd_s2;
  assign wr_rise = wr_ok & ~wr_d & wr_s2;
  assign wr_fall = wr_ok & wr_d & ~wr_s2;

  // RX FIFO (host or loopback -> master)
  logic [7:0]     rx_mem [RXD];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0] rx_cnt;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]     rx_push_dat;

  // TX FIFO (master -> host)
  logic [7:0]     tx_mem [TXD];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0] tx_cnt;
  logic           tx_full, tx_empty, tx_push, tx_pop;

  assign rx_full  = (rx_cnt == (RX_AW+1)'(RXD));
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == (TX_AW+1)'(TXD));
  assign tx_empty = (tx_cnt == '0);

  rstate_t        r_st, r_nxt;
  wstate_t        w_st, w_nxt;
  logic [RCW-1:0] r_cnt;
  logic [WCW-1:0] w_cnt;
  logic           drv;
  logic [7:0]     dout;
  logic [1:0]     err_q;
  logic           w_push, w_tgt_full;

  assign w_tgt_full = lb ? rx_full : tx_full;

  always_comb begin
    r_nxt = r_st;
    rx_pop = 1'b0;
    case (r_st)
      R_IDLE:  if (rd_fall) r_nxt = R_DRIVE;
      R_DRIVE: if (rd_rise) begin
        r_nxt  = R_INACT;
        rx_pop = ~rx_empty;
      end
      R_INACT: if (r_cnt == RCW'(RXF_INACT - 1)) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_nxt  = w_st;
    w_push = 1'b0;
    case (w_st)
      W_IDLE:  if (wr_rise) w_nxt = W_ARMED;
      W_ARMED: if (wr_fall) begin
        w_nxt  = W_INACT;
        w_push = 1'b1;
      end
      W_INACT: if (w_cnt == WCW'(TXE_INACT - 1)) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rx_push     = 1'b0;
    rx_push_dat = HOST_RXD;
    tx_push     = 1'b0;
    tx_pop      = 1'b0;
    if (lb) begin
      rx_push     = w_push & ~rx_full;
      rx_push_dat = wr_byte;
    end else begin
      rx_push = HOST_RXV & ~rx_full;
      tx_push = w_push & ~tx_full;
      tx_pop  = HOST_TXACK & ~tx_empty;
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wp] <= rx_push_dat;
    if (tx_push) tx_mem[tx_wp] <= wr_byte;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
      rx_cnt <= rx_cnt + {RX_AW'(0), rx_push} - {RX_AW'(0), rx_pop};
      if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
      tx_cnt <= tx_cnt + {TX_AW'(0), tx_push} - {TX_AW'(0), tx_pop};
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_st  <= R_IDLE;
      w_st  <= W_IDLE;
      r_cnt <= '0;
      w_cnt <= '0;
      drv   <= 1'b0;
      dout  <= 8'h00;
      err_q <= 2'b00;
    end else begin
      r_st  <= r_nxt;
      w_st  <= w_nxt;
      r_cnt <= (r_st == R_INACT && r_nxt == R_INACT) ? r_cnt + RCW'(1) : '0;
      w_cnt <= (w_st == W_INACT && w_nxt == W_INACT) ? w_cnt + WCW'(1) : '0;
      if (r_st == R_IDLE && rd_fall) begin
        drv  <= 1'b1;
        dout <= rx_empty ? 8'h00 : rx_mem[rx_rp];
        if (rx_empty) err_q[0] <= 1'b1;
      end else if (r_st == R_DRIVE && rd_rise) begin
        drv <= 1'b0;
      end
      if (w_push && w_tgt_full) err_q[1] <= 1'b1;
    end
  end

  assign USBX       = drv ? dout : 8'hzz;
  assign RXF        = ~live | (r_st == R_INACT) | rx_empty;
  assign TXE        = ~live | (w_st == W_INACT) | w_tgt_full;
  assign HOST_RXRDY = live & ~rx_full;
  assign HOST_TXD   = tx_mem[tx_rp];
  assign HOST_TXV   = ~tx_empty;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Directed + randomized bench for ft245_fifo_responder; FIFO contents and sticky errors modelled with queues.
module tb_ft245_fifo_responder;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rd = 1'b1;
  logic       wr = 1'b0;
  logic       loopback = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dat = 8'h00;
  wire  [7:0] usbx;
  logic       rxf, txe, host_rxrdy, host_txv;
  logic [7:0] host_rxd = 8'h00;
  logic       host_rxv = 1'b0;
  logic [7:0] host_txd;
  logic       host_txack = 1'b0;
  logic [1:0] err;

  assign usbx = tb_oe ? tb_dat : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (usbx[gi]);
  end

  always #4 clk = ~clk;

  ft245_fifo_responder dut (
    .CLK(clk), .RSTN(rstn),
`ifdef FT_LOOPBACK_EN
    .LOOPBACK(loopback),
`endif
    .RD(rd), .WR(wr), .USBX(usbx), .RXF(rxf), .TXE(txe),
    .HOST_RXD(host_rxd), .HOST_RXV(host_rxv), .HOST_RXRDY(host_rxrdy),
    .HOST_TXD(host_txd), .HOST_TXV(host_txv), .HOST_TXACK(host_txack), .ERR(err)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [1:0] err_m = 2'b00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_rxrdy"}, 8'(host_rxrdy), 8'(rxq.size() < RXD));
    chk({tag, "_txv"}, 8'(host_txv), 8'(txq.size() > 0));
    if (txq.size() > 0) chk({tag, "_txd"}, host_txd, txq[0]);
    chk({tag, "_err"}, 8'(err), 8'(err_m));
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    host_rxd = b;
    host_rxv = 1'b1;
    @(negedge clk);
    host_rxv = 1'b0;
    if (!loopback && rxq.size() < RXD) rxq.push_back(b);
  endtask

  task automatic host_ack();
    @(negedge clk);
    host_txack = 1'b1;
    @(negedge clk);
    host_txack = 1'b0;
    if (!loopback && txq.size() > 0) void'(txq.pop_front());
  endtask

  // One master read; optional host push lands in the same cycle as the pop.
  task automatic master_read(input string tag, input int low_cyc, input bit co_push,
                             input logic [7:0] co_byte);
    logic [7:0] exp;
    bit was_full;
    if (rxq.size() > 0) exp = rxq[0];
    else begin
      exp = 8'h00;
      err_m[0] = 1'b1;
    end
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk({tag, "_usbx"}, usbx, exp);
    repeat (low_cyc - 3) @(posedge clk);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (co_push) begin
      host_rxd = co_byte;
      host_rxv = 1'b1;
    end
    @(posedge clk);
    #1;
    was_full = (rxq.size() == RXD);
    if (rxq.size() > 0) void'(rxq.pop_front());
    if (co_push && !was_full) rxq.push_back(co_byte);
    chk({tag, "_rxf_inact0"}, 8'(rxf), 8'h01);
    chk({tag, "_usbx_z"}, usbx, 8'hFF);
    chk({tag, "_err"}, 8'(err), 8'(err_m));
    @(negedge clk);
    host_rxv = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk({tag, "_rxf_inact9"}, 8'(rxf), 8'h01);
    @(posedge clk);
    #1 chk({tag, "_rxf_idle"}, 8'(rxf), 8'(rxq.size() == 0));
  endtask

  task automatic master_write(input string tag, input logic [7:0] b);
    bit full;
    @(negedge clk);
    tb_dat = b;
    tb_oe  = 1'b1;
    wr     = 1'b1;
    repeat (4) @(negedge clk);
    wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (loopback) begin
      if (rxq.size() < RXD) rxq.push_back(b); else err_m[1] = 1'b1;
    end else begin
      if (txq.size() < TXD) txq.push_back(b); else err_m[1] = 1'b1;
    end
    chk({tag, "_txe_inact0"}, 8'(txe), 8'h01);
    chk({tag, "_err"}, 8'(err), 8'(err_m));
    tb_oe = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk({tag, "_txe_inact9"}, 8'(txe), 8'h01);
    @(posedge clk);
    full = loopback ? (rxq.size() == RXD) : (txq.size() == TXD);
    #1 chk({tag, "_txe_idle"}, 8'(txe), 8'(full));
  endtask

  initial begin
    logic [7:0] b;
    // Reset state
    #3;
    chk("rst_rxf", 8'(rxf), 8'h01);
    chk("rst_txe", 8'(txe), 8'h01);
    chk("rst_usbx", usbx, 8'hFF);
    chk("rst_err", 8'(err), 8'h00);
    chk("rst_txv", 8'(host_txv), 8'h00);
    chk("rst_rxrdy", 8'(host_rxrdy), 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_txe", 8'(txe), 8'h00);
    chk("rel_rxrdy", 8'(host_rxrdy), 8'h01);
    chk("rel_rxf", 8'(rxf), 8'h01);
    repeat (5) @(posedge clk);

    // Single byte host -> master
    host_push(8'h07);
    chk("t2_rxf_before", 8'(rxf), 8'h00);
    master_read("t2", 6, 1'b0, 8'h00);

    // Two master writes, drained by host
    master_write("t3a", 8'hA5);
    master_write("t3b", 8'h5A);
    chk_state("t3_head");
    host_ack();
    chk_state("t3_ack1");
    host_ack();
    chk_state("t3_ack2");

    // RX fill, overflow drop, drain, read-while-empty
    for (int i = 0; i < 17; i++) host_push(8'(i));
    chk_state("t4_full");
    for (int i = 0; i < 17; i++) master_read($sformatf("t4_rd%0d", i), 4, 1'b0, 8'h00);
    chk("t4_err", 8'(err), 8'h01);

    // TX fill, 17th write dropped
    for (int i = 0; i < 17; i++) master_write($sformatf("t5_wr%0d", i), 8'($urandom_range(0, 254)));
    chk("t5_err", 8'(err), 8'h03);
    for (int i = 0; i < 16; i++) begin
      chk_state($sformatf("t5_drain%0d", i));
      host_ack();
    end
    chk_state("t5_empty");

    // Simultaneous host push and RD pop, then randomized mix
    for (int i = 0; i < 3; i++) host_push(8'($urandom_range(0, 254)));
    master_read("co", 5, 1'b1, 8'h6E);
    chk_state("co_after");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: host_push(8'($urandom_range(0, 254)));
        1: master_read($sformatf("rnd%0d", n), $urandom_range(4, 8),
                       bit'(rxq.size() > 0 && rxq.size() < RXD && $urandom_range(0, 1) == 1),
                       8'($urandom_range(0, 254)));
        2: master_write($sformatf("rnd%0d", n), 8'($urandom_range(0, 254)));
        default: host_ack();
      endcase
      chk_state($sformatf("rnd%0d", n));
    end

`ifdef FT_LOOPBACK_EN
    while (rxq.size() > 0) master_read("lb_flush", 4, 1'b0, 8'h00);
    loopback = 1'b1;
    master_write("lb_wr", 8'h08);
    master_read("lb_rd", 5, 1'b0, 8'h00);
    loopback = 1'b0;
`endif

    // Reset asserted while the DUT is driving USBX, strobes held across release
    host_push(8'h3C);
    @(negedge clk);
    rd = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_usbx_drv", usbx, (rxq.size() > 0) ? rxq[0] : 8'h00);
    #2 rstn = 1'b0;
    #1;
    chk("mid_usbx_z", usbx, 8'hFF);
    chk("mid_rxf", 8'(rxf), 8'h01);
    chk("mid_err", 8'(err), 8'h00);
    rxq.delete();
    txq.delete();
    err_m = 2'b00;
    tb_dat = 8'h5A;
    tb_oe  = 1'b1;
    wr     = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    repeat (4) @(posedge clk);
    tb_oe = 1'b0;
    #1 chk("rel_usbx_z", usbx, 8'hFF);
    repeat (12) @(posedge clk);
    #1 chk("rel_txe_idle", 8'(txe), 8'h00);
    chk_state("rel_wr_ignored");
    @(negedge clk);
    rd = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("rel_rxf_idle", 8'(rxf), 8'h01);
    chk_state("rel_rd_ignored");
    master_read("post_rst_rd", 4, 1'b0, 8'h00);
    b = 8'($urandom_range(0, 254));
    master_write("post_rst_wr", b);
    chk_state("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
